// File: rtl/reg_file_dump.sv
// Debug read-out engine: walks the architectural registers through one reg file
// read port and streams (index, value) beats over a valid/ready interface.
module reg_file_dump #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_reg,
    input  logic [XLEN-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic [XLEN-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] idx;
    logic       handshake;

    assign handshake = (state == SEND) && out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Terminal test comes before the increment, so idx never wraps.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    state_next = SEND;
            SEND:    if (handshake) state_next = (idx == LAST_IDX) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The beat is captured at the end of READ, so a write landing on that same
    // edge is not part of the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) idx <= '0;
                end
                READ: begin
                    out_data  <= rd_data;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (idx != LAST_IDX) idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign rd_reg = (state == READ) ? idx : '0;

endmodule
